// File: rtl/hht_fetch_seq.sv
// Two-stage column-index / vector-value gather sequencer with an in-order output FIFO.
// Optional bounds check on gathered indices is enabled by defining HHT_FETCH_BOUNDS_EN.
module hht_fetch_seq #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int DEPTH  = 4,
    parameter int V_SIZE = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          start,
    input  logic [AW-1:0] col_base,
    input  logic [AW-1:0] vval_base,
    input  logic [31:0]   csize,
    output logic [AW-1:0] addr1,
    output logic          en1,
    input  logic [DW-1:0] dataIn1,
    output logic [AW-1:0] addr2,
    output logic          en2,
    input  logic [DW-1:0] dataIn2,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] out_col,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Pointer wrap relies on DEPTH being a power of two; the bound only matters with the check enabled.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || V_SIZE < 1) begin : g_bad_param
        $error("hht_fetch_seq: DEPTH must be a power of two >= 2 and V_SIZE >= 1");
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DW-1:0] col;
        logic          last;
    } entry_t;

    logic [1:0]    state, next_state;
    logic [AW-1:0] col_base_q, vval_base_q;
    logic [31:0]   csize_q, idx;
    logic          b_valid, b_last;
    logic [DW-1:0] b_col;
    logic [AW-1:0] addr1_q, addr2_q;
    entry_t        fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;

    logic accept, issue, issue_last, pop, bad_col, drain_done;

    assign accept     = (state == S_IDLE) && start;
    // Credit counts the word already in stage B; a same-cycle pop is deliberately not credited.
    assign issue      = (state == S_RUN) && ((32'(fifo_count) + 32'(b_valid)) < 32'(DEPTH));
    assign issue_last = (idx == csize_q - 32'd1);
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    assign drain_done = !b_valid && ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

`ifdef HHT_FETCH_BOUNDS_EN
    logic err_q;
    assign bad_col = b_valid && (b_col >= DW'(V_SIZE));
    assign err     = err_q;
`else
    assign bad_col = 1'b0;
    assign err     = 1'b0;
`endif

    assign en1   = issue;
    assign addr1 = issue ? (col_base_q + AW'(idx)) : addr1_q;
    assign en2   = b_valid && !bad_col;
    assign addr2 = en2 ? (vval_base_q + AW'(b_col)) : addr2_q;

    assign out_data = fifo_mem[rd_ptr].data;
    assign out_col  = fifo_mem[rd_ptr].col;
    assign out_last = fifo_mem[rd_ptr].last;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    // NOTE: next_state is assigned a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = (csize == 32'd0) ? S_DONE : S_RUN;
            S_RUN:   if (issue && issue_last) next_state = S_DRAIN;
            S_DRAIN: if (drain_done) next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= S_IDLE;
            col_base_q  <= '0;
            vval_base_q <= '0;
            csize_q     <= '0;
            idx         <= '0;
            b_valid     <= 1'b0;
            b_col       <= '0;
            b_last      <= 1'b0;
            addr1_q     <= '0;
            addr2_q     <= '0;
        end else begin
            state   <= next_state;
            b_valid <= issue;
            if (accept) begin
                col_base_q  <= col_base;
                vval_base_q <= vval_base;
                csize_q     <= csize;
                idx         <= '0;
            end else if (issue) begin
                idx <= idx + 32'd1;
            end
            if (issue) begin
                b_col   <= dataIn1;
                b_last  <= issue_last;
                addr1_q <= addr1;
            end
            if (en2) addr2_q <= addr2;
        end
    end

    // NOTE: the FIFO storage is reset (it is only DEPTH entries) so out_data/out_col/out_last read 0 after reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int k = 0; k < DEPTH; k++) fifo_mem[k] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (b_valid) begin
                fifo_mem[wr_ptr] <= '{data: bad_col ? '0 : dataIn2, col: b_col, last: b_last};
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({b_valid, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef HHT_FETCH_BOUNDS_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)         err_q <= 1'b0;
        else if (accept)  err_q <= 1'b0;
        else if (bad_col) err_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_hht_fetch_seq.sv
// Bench for hht_fetch_seq: table of walks against combinational memory models, checked
// through an expected-output queue, plus hand-written reset and bounds sequences.
module tb_hht_fetch_seq;

    localparam int DW = 32, AW = 32, DEPTH = 4, V_SIZE = 16;
`ifdef HHT_FETCH_BOUNDS_EN
    localparam bit BOUNDS_ON = 1'b1;
`else
    localparam bit BOUNDS_ON = 1'b0;
`endif

    logic          Clk, Rst, start, out_ready;
    logic [AW-1:0] col_base, vval_base, addr1, addr2;
    logic [31:0]   csize;
    logic [DW-1:0] dataIn1, dataIn2, out_data, out_col;
    logic          en1, en2, out_last, out_valid, busy, done, err;

    logic [31:0] col_mem [256];
    logic [31:0] val_mem [256];

    hht_fetch_seq #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .V_SIZE(V_SIZE)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .col_base(col_base), .vval_base(vval_base),
        .csize(csize), .addr1(addr1), .en1(en1), .dataIn1(dataIn1), .addr2(addr2),
        .en2(en2), .dataIn2(dataIn2), .out_data(out_data), .out_col(out_col),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign dataIn1 = (addr1 < 32'd256) ? col_mem[addr1[7:0]] : '0;
    assign dataIn2 = (addr2 < 32'd256) ? val_mem[addr2[7:0]] : '0;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] col;
        logic        last;
    } exp_t;

    typedef struct {
        logic [31:0] col_base;
        logic [31:0] vval_base;
        logic [31:0] csize;
        int          stall;
        bit          ign;
        logic [31:0] first_data;
        logic [31:0] last_data;
    } vec_t;

    exp_t exp_q [$];
    vec_t vecs [6];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    function automatic logic [31:0] col_val(input logic [31:0] a);
        return (a < 32'd256) ? col_mem[a[7:0]] : 32'd0;
    endfunction

    function automatic logic [31:0] val_val(input logic [31:0] a);
        return (a < 32'd256) ? val_mem[a[7:0]] : 32'd0;
    endfunction

    function automatic bit out_of_range(input logic [31:0] c);
        return BOUNDS_ON && (c >= 32'(V_SIZE));
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_en1"}, en1, 0);
        check({tag, "_en2"}, en2, 0);
        check({tag, "_addr1"}, addr1, 0);
        check({tag, "_addr2"}, addr2, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_col"}, out_col, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic run_walk(input vec_t v);
        int          cyc, last_pop_cyc, n_pop;
        bit          done_seen, ov_seen, en1_seen, en2_seen, exp_err;
        exp_t        e;
        logic [31:0] c, first_d, last_d;
        exp_q.delete();
        exp_err = 1'b0;
        for (int k = 0; k < int'(v.csize); k++) begin
            c      = col_val(v.col_base + 32'(k));
            e.col  = c;
            e.last = (k == int'(v.csize) - 1);
            e.data = out_of_range(c) ? 32'd0 : val_val(v.vval_base + c);
            if (out_of_range(c)) exp_err = 1'b1;
            exp_q.push_back(e);
        end
        col_base  = v.col_base;
        vval_base = v.vval_base;
        csize     = v.csize;
        out_ready = (v.stall == 0);
        start     = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        cyc = 0; last_pop_cyc = -1; n_pop = 0;
        done_seen = 0; ov_seen = 0; en1_seen = 0; en2_seen = 0;
        first_d = '0; last_d = '0;
        while (!done_seen && cyc < 300) begin
            @(negedge Clk);
            cyc++;
            if (v.stall > 0) out_ready = (cyc > v.stall);
            if (v.ign && cyc == 2) begin
                start = 1'b1; col_base = 32'd0; vval_base = 32'd0; csize = 32'd9;
            end else if (v.ign && cyc == 3) begin
                start = 1'b0;
            end
            if (cyc == 1) check("busy_e0p1", busy, 1);
            if (cyc == 1 && v.csize != 0) begin
                check("en1_e0p1", en1, 1);
                check("addr1_e0p1", addr1, v.col_base);
            end
            if (cyc == 2 && v.csize != 0) begin
                c = col_val(v.col_base);
                check("en2_e0p2", en2, !out_of_range(c));
                if (!out_of_range(c)) check("addr2_e0p2", addr2, v.vval_base + c);
            end
            if (v.stall > 0 && cyc == v.stall) begin
                check("stall_en1_low", en1, 0);
                check("stall_out_valid", out_valid, 1);
                check("stall_busy", busy, 1);
            end
            en1_seen |= en1;
            en2_seen |= en2;
            if (out_valid && !ov_seen) begin
                ov_seen = 1'b1;
                check("first_valid_cycle", cyc, 3);
            end
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_col", out_col, e.col);
                    check("out_last", out_last, e.last);
                end
                if (n_pop == 1) first_d = out_data;
                last_d = out_data;
                if (out_last) last_pop_cyc = cyc;
            end
            if (done) begin
                done_seen = 1'b1;
                if (v.csize == 0) check("done_cycle_zero_len", cyc, 1);
                else check("done_after_last_pop", cyc, last_pop_cyc + 1);
            end
        end
        check("walk_completed", done_seen, 1);
        check("pop_count", n_pop, v.csize);
        if (v.csize == 0) begin
            check("zero_len_en1", en1_seen, 0);
            check("zero_len_en2", en2_seen, 0);
            check("zero_len_out_valid", ov_seen, 0);
        end else begin
            check("first_data", first_d, v.first_data);
            check("last_data", last_d, v.last_data);
        end
        check("err_flag", err, exp_err);
        @(negedge Clk);
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        check("idle_en1", en1, 0);
        if (v.csize != 0) check("addr1_hold", addr1, v.col_base + v.csize - 32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        vec_t v;
        for (int k = 0; k < 256; k++) begin
            col_mem[k] = 32'(k % 16);
            val_mem[k] = 32'(1000 + k);
        end
        col_mem[180] = 15; col_mem[181] = 2; col_mem[182] = 11; col_mem[183] = 7;
        begin
            int vals [16] = '{7, 93, 68, 80, 90, 15, 4, 8, 35, 81, 45, 52, 48, 69, 100, 34};
            for (int k = 0; k < 16; k++) val_mem[k + 2] = 32'(vals[k]);
        end

        // col_base, vval_base, csize, stall cycles, ignored start, first data, last data
        vecs[0] = '{180, 2, 4, 0,  1'b0, 34,   8};
        vecs[1] = '{180, 2, 6, 10, 1'b0, 34,   81};
        vecs[2] = '{180, 3, 4, 0,  1'b0, 1018, 35};
        vecs[3] = '{180, 2, 0, 0,  1'b0, 0,    0};
        vecs[4] = '{180, 2, 4, 0,  1'b1, 34,   8};
        vecs[5] = '{181, 2, 1, 0,  1'b0, 68,   68};

        Rst = 1'b0; start = 1'b0; out_ready = 1'b1;
        col_base = '0; vval_base = '0; csize = '0;
        repeat (2) @(negedge Clk);
        check_reset_vals("por");
        Rst = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 6; i++) run_walk(vecs[i]);

        // Reset in the middle of a walk, then a fresh short walk.
        col_base = 180; vval_base = 2; csize = 4; start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        #1 check_reset_vals("mid_rst");
        @(negedge Clk);
        check("mid_rst_no_done", done, 0);
        Rst = 1'b1;
        @(negedge Clk);
        check("post_rst_no_done", done, 0);
        check("post_rst_idle", busy, 0);
        v = '{180, 2, 2, 0, 1'b0, 34, 68};
        run_walk(v);

        // Out-of-range column index at the head of the walk.
        col_mem[180] = 20;
        v = '{180, 2, 4, 0, 1'b0, BOUNDS_ON ? 32'd0 : 32'd1022, 8};
        run_walk(v);
        col_mem[180] = 15;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
